mem_loader: RTL and testbench

Program/data loader sitting directly upstream of the ideal memory write port in the single-cycle MIPS evaluation system. It accepts a stream of 32-bit words over a valid/ready interface and writes them to consecutive word addresses starting at a programmable base. While loading, it holds the CPU core in reset, and it releases the core once the image is complete. This replaces hard-coded `initial` images with a runtime-loadable image for both simulation and board bring-up.

---
 rtl/mem_loader_pkg.sv | 13 +
 rtl/mem_loader_if.sv | 25 ++
 rtl/mem_loader_csum.sv | 28 ++
 rtl/mem_loader.sv | 127 ++++++++++++
 tb/tb_mem_loader.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loader_pkg.sv
// Shared constants for the memory loader: data width, word type and FSM state encoding.
package mem_loader_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mem_loader_if.sv
// Stream-in and memory-write bundle of the loader.
// The slave view is taken by the loader; the master view is taken by the stream source/memory side.
interface mem_loader_if #(
    parameter int ADDR_WIDTH = 10
) ();
    import mem_loader_pkg::*;

    logic                  s_valid;
    word_t                 s_data;
    logic                  s_ready;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    word_t                 mem_wdata;
    logic                  mem_wren;

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_waddr, mem_wdata, mem_wren
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_waddr, mem_wdata, mem_wren
    );

endinterface

// File: rtl/mem_loader_csum.sv
// Running 32-bit sum of loaded words, and the comparison of that sum against the trailer word.
module mem_loader_csum
    import mem_loader_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  acc,
    input  word_t data,
    output logic  match
);

    word_t sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (acc) begin
            sum <= sum + data;
        end
    end

    // The trailer arrives on the same data lane, so compare against the live word.
    assign match = (data == sum);

endmodule

// File: rtl/mem_loader.sv
// Streams words into consecutive memory locations and holds the CPU in reset while loading.
// Define MEM_LOADER_CHECKSUM_EN to require a trailing checksum word after the data words.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_WORDS  = 2 ** (ADDR_WIDTH - 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    mem_loader_if.slave           bus,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic                  wren_r;
    logic [ADDR_WIDTH-1:0] waddr_r;
    word_t                 wdata_r;
    logic                  accepting;
    logic                  beat;
    logic                  start_ok;
    logic                  range_bad;
    logic [ADDR_WIDTH:0]   end_idx;

    assign accepting     = (state == ST_LOAD) || (state == ST_CHECK);
    assign busy          = accepting;
    assign bus.s_ready   = accepting;
    assign beat          = bus.s_valid && accepting;
    assign start_ok      = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign bus.mem_waddr = waddr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.mem_wren  = wren_r;

    // One extra bit so base+count cannot wrap before the bound is compared.
    assign end_idx   = {1'b0, base_addr} + {1'b0, word_count};
    assign range_bad = end_idx > MEM_LIMIT;

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam logic [1:0] ST_AFTER_DATA = ST_CHECK;

    logic csum_match;

    mem_loader_csum u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .acc   (beat && (state == ST_LOAD)),
        .data  (bus.s_data),
        .match (csum_match)
    );
`else
    localparam logic [1:0] ST_AFTER_DATA = ST_DONE;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            wren_r    <= 1'b0;
            waddr_r   <= '0;
            wdata_r   <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            wren_r <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        addr      <= base_addr;
                        remaining <= word_count;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        cpu_rst_n <= 1'b0;
                        if (range_bad) begin
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end else if (word_count == '0) begin
                            state <= ST_AFTER_DATA;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end else if (state == ST_DONE) begin
                        done      <= 1'b1;
                        cpu_rst_n <= !err;
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        wren_r    <= 1'b1;
                        waddr_r   <= addr;
                        wdata_r   <= bus.s_data;
                        addr      <= addr + ADDR_WIDTH'(1);
                        remaining <= remaining - ADDR_WIDTH'(1);
                        if (remaining == ADDR_WIDTH'(1)) begin
                            state <= ST_AFTER_DATA;
                        end
                    end
                end
`ifdef MEM_LOADER_CHECKSUM_EN
                // Trailer word: consumed here, never written to memory.
                ST_CHECK: begin
                    if (beat) begin
                        err       <= !csum_match;
                        cpu_rst_n <= csum_match;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized self-checking bench for mem_loader against a behavioural image/handshake model.
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int AW = 10;
    localparam int MW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] word_count = '0;
    logic          cpu_rst_n, busy, done, err;

    mem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    mem_loader #(.ADDR_WIDTH(AW), .MEM_WORDS(MW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .bus        (bus.slave),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          a;
        logic [31:0] d;
        int          c;
    } wr_t;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_wren = 0;
    logic [31:0] obs_mem[1024];
    logic [31:0] exp_mem[1024];
    logic [31:0] words[64];
    wr_t         obs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Behaves as the ideal memory: captures every write the loader issues.
    always @(negedge clk) begin
        if (bus.mem_wren === 1'b1) begin
            obs_mem[bus.mem_waddr] = bus.mem_wdata;
            obs_q.push_back('{int'(bus.mem_waddr), bus.mem_wdata, cyc});
            n_wren++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, bus.s_ready, 0);
        check({tag, "_wren"}, bus.mem_wren, 0);
        check({tag, "_waddr"}, bus.mem_waddr, 0);
        check({tag, "_wdata"}, bus.mem_wdata, 0);
        check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic do_start(input int b, input int c, output int t0);
        base_addr  = AW'(b);
        word_count = AW'(c);
        start      = 1'b1;
        t0         = cyc;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_words(input int n, input int maxgap, input bit rndgap, input bit pulse);
        for (int i = 0; i < n; i++) begin
            int g;
            bit acc;
            g = rndgap ? $urandom_range(maxgap, 0) : maxgap;
            for (int k = 0; k < g; k++) begin
                bus.s_valid = 1'b0;
                bus.s_data  = $urandom;
                start       = pulse ? 1'($urandom_range(1, 0)) : 1'b0;
                base_addr   = AW'($urandom);
                check("busy_gap", busy, 1);
                check("ready_gap", bus.s_ready, 1);
                @(negedge clk);
            end
            bus.s_valid = 1'b1;
            bus.s_data  = words[i];
            acc = 1'b0;
            for (int k = 0; k < 64 && !acc; k++) begin
                start = pulse ? 1'($urandom_range(1, 0)) : 1'b0;
                if (bus.s_ready) acc = 1'b1;
                @(negedge clk);
            end
            if (!acc) check("beat_accept", 0, 1);
        end
        bus.s_valid = 1'b0;
        start       = 1'b0;
    endtask

    task automatic run_load(input int b, input int c, input int maxgap, input bit rndgap,
                            input bit pulse, input bit bad_trl, output int t0, output int td);
        bit          rerr, exp_err, exp_busy;
        int          nsend, mism, wr0, expc;
        logic [31:0] sum;
        rerr     = (b + c) > MW;
        exp_err  = rerr;
        exp_busy = !rerr && (c != 0);
        nsend    = c;
        sum      = '0;
        for (int i = 0; i < c; i++) sum = sum + words[i];
`ifdef MEM_LOADER_CHECKSUM_EN
        words[c] = bad_trl ? sum + 32'd1 : sum;
        if (!rerr && bad_trl) exp_err = 1'b1;
        exp_busy = !rerr;
        nsend    = c + 1;
`endif
        obs_q.delete();
        wr0 = n_wren;
        do_start(b, c, t0);
        check("start_busy", busy, exp_busy);
        check("start_cpu_rst_n", cpu_rst_n, 0);
        if (rerr) begin
            bus.s_valid = 1'b1;
            bus.s_data  = $urandom;
            check("err_ready", bus.s_ready, 0);
            @(negedge clk);
        end else begin
            send_words(nsend, maxgap, rndgap, pulse);
        end
        td = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                td = cyc;
                break;
            end
            @(negedge clk);
        end
        check("done_rise", td >= 0, 1);
        check("end_err", err, exp_err);
        check("end_cpu_rst_n", cpu_rst_n, !exp_err);
        check("end_busy", busy, 0);
        // Stray stream data after completion must be refused.
        mism = 0;
        bus.s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (bus.s_ready !== 1'b0) mism++;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        check("done_ready_low", mism, 0);
        check("done_sticky", done, 1);
        expc = rerr ? 0 : c;
        check("wr_count", obs_q.size(), expc);
        check("wren_total", n_wren - wr0, expc);
        mism = 0;
        for (int i = 0; i < obs_q.size() && i < expc; i++) begin
            if (obs_q[i].a != b + i || obs_q[i].d !== words[i]) mism++;
        end
        check("wr_seq", mism, 0);
        if (!rerr) for (int i = 0; i < c; i++) exp_mem[b + i] = words[i];
        mism = 0;
        for (int i = 0; i < 1024; i++) if (obs_mem[i] !== exp_mem[i]) mism++;
        check("mem_image", mism, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, td;
        for (int i = 0; i < 1024; i++) begin
            obs_mem[i] = '0;
            exp_mem[i] = '0;
        end
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: three back-to-back words from address 0.
        words[0] = 32'h24010064;
        words[1] = 32'h24010065;
        words[2] = 32'h24020064;
        run_load(0, 3, 0, 0, 0, 0, t0, td);
        check("t1_done_cyc", td, t0 + 5);
        for (int i = 0; i < 3; i++)
            check("t1_wr_cyc", (i < obs_q.size()) ? obs_q[i].c : -1, t0 + 2 + i);

        // Gaps of three idle cycles between beats.
        words[0] = $urandom;
        words[1] = $urandom;
        run_load(200, 2, 3, 0, 0, 0, t0, td);

        // Range error: nothing written, core stays in reset.
        run_load(250, 10, 0, 0, 0, 0, t0, td);
        check("rerr_done_cyc", td, t0 + 2);

        // Exact fit up to the last memory word.
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        run_load(250, 6, 1, 1, 0, 0, t0, td);

        // Zero-length image.
        run_load(17, 0, 0, 0, 0, 0, t0, td);
`ifndef MEM_LOADER_CHECKSUM_EN
        check("zero_done_cyc", td, t0 + 2);
`endif

        // Reset after the first of four beats.
        words[0] = $urandom;
        do_start(40, 4, t0);
        bus.s_valid = 1'b1;
        bus.s_data  = words[0];
        @(negedge clk);
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_mem[40] = words[0];
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        run_load(40, 4, 1, 1, 0, 0, t0, td);

        // start and base_addr toggled while loading must be ignored.
        for (int i = 0; i < 12; i++) words[i] = $urandom;
        run_load(100, 12, 2, 1, 1, 0, t0, td);

`ifdef MEM_LOADER_CHECKSUM_EN
        words[0] = 32'd1;
        words[1] = 32'd2;
        words[2] = 32'd3;
        run_load(60, 3, 0, 0, 0, 0, t0, td);
        check("csum_ok_err", err, 0);
        words[0] = 32'd1;
        words[1] = 32'd2;
        words[2] = 32'd3;
        run_load(60, 3, 0, 0, 0, 1, t0, td);
        check("csum_bad_err", err, 1);
`endif

        // Randomized images, occasionally out of range.
        for (int it = 0; it < 12; it++) begin
            int b, c;
            b = $urandom_range(300, 0);
            c = $urandom_range(24, 0);
            for (int i = 0; i < c; i++) words[i] = $urandom;
            run_load(b, c, 2, 1, it[0], it[1], t0, td);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
